// File: rtl/word_lsb_serializer_pkg.sv
// Shared types for the word_lsb_serializer slice: FSM state encoding and default width.
// PAR is only reachable when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

    localparam int SER_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/word_lsb_serializer_if.sv
// Parallel-in / serial-out handshake bundle for word_lsb_serializer.
// slave is the serializer side, master is the upstream/downstream environment side.
interface word_lsb_serializer_if
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_data, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_data, ser_last, busy
    );

endinterface

// File: rtl/word_lsb_serializer_chk.sv
// Checker for the serializer: the bit counter must stay below WIDTH while shifting.
module ser_cnt_checker
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input logic             c,
    input logic             r,
    input ser_state_e       state,
    input logic [CNT_W-1:0] cnt
);

    a_cnt_in_range: assert property (@(posedge c) disable iff (r)
        !((state == SHIFT) && (cnt >= CNT_W'(WIDTH))));

endmodule

// File: rtl/word_lsb_serializer_cnt.sv
// Bit counter for the serializer: synchronous clear has priority over increment,
// tc flags the final data bit so the FSM can leave SHIFT without cnt ever reaching WIDTH.
module ser_bit_counter #(
    parameter int CNT_W = 6,
    parameter int TERM  = 31
) (
    input  logic             c,
    input  logic             r,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear on load or frame end, advance per accepted bit.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == TERM_C);

endmodule

// File: rtl/word_lsb_serializer.sv
// LSB-first word serializer with valid/ready on both sides, one word in flight.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module word_lsb_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_DEF_WIDTH
) (
    input logic                  c,
    input logic                  r,
    word_lsb_serializer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    ser_state_e       state_r;
    ser_state_e       state_s;
    logic [WIDTH-1:0] sreg_r;
    logic [CNT_W-1:0] cnt_s;
    logic             tc_s;
    logic             clr_s;
    logic             inc_s;
    logic             load_s;
    logic             shift_s;
    logic             ser_data_s;
    logic             ser_last_s;

`ifdef SERIALIZER_PARITY_EN
    logic parity_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    ser_bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (WIDTH - 1)
    ) u_cnt (
        .c   (c),
        .r   (r),
        .clr (clr_s),
        .inc (inc_s),
        .cnt (cnt_s),
        .tc  (tc_s)
    );

    ser_cnt_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .c     (c),
        .r     (r),
        .state (state_r),
        .cnt   (cnt_s)
    );

    // Next-state and datapath control; the counter is cleared on the final bit rather than incremented.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        clr_s   = 1'b0;
        inc_s   = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    load_s  = 1'b1;
                    clr_s   = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    shift_s = 1'b1;
                    if (tc_s) begin
                        clr_s = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                        state_s = PAR;
`else
                        state_s = IDLE;
`endif
                    end else begin
                        inc_s = 1'b1;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            PAR: begin
`ifdef SERIALIZER_PARITY_EN
                if (bus.ser_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = PAR;
                end
`else
                state_s = IDLE;
`endif
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register: zeros enter at the MSB so sreg_r[0] is always the next bit out.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            sreg_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            sreg_r <= bus.in_data;
        end else if (shift_s) begin
            sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
        end else begin
            sreg_r <= sreg_r;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    // Parity of the captured word, sent after the data bits.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= even_parity(bus.in_data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // Serial outputs decoded from registered state only, so they stay put while stalled.
    always_comb begin
        ser_data_s = 1'b0;
        ser_last_s = 1'b0;
        case (state_r)
            SHIFT: begin
                ser_data_s = sreg_r[0];
`ifdef SERIALIZER_PARITY_EN
                ser_last_s = 1'b0;
`else
                ser_last_s = tc_s;
`endif
            end
            PAR: begin
`ifdef SERIALIZER_PARITY_EN
                ser_data_s = parity_r;
                ser_last_s = 1'b1;
`else
                ser_data_s = 1'b0;
                ser_last_s = 1'b0;
`endif
            end
            default: begin
                ser_data_s = 1'b0;
                ser_last_s = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.ser_valid = (state_r == SHIFT) || (state_r == PAR);
    assign bus.ser_data  = ser_data_s;
    assign bus.ser_last  = ser_last_s;

endmodule

// File: tb/tb_word_lsb_serializer.sv
// Scoreboard bench for word_lsb_serializer: accepted words push expected bits, a monitor pops and compares.
module tb_word_lsb_serializer;
    import serializer_pkg::*;

    localparam int WIDTH = 32;

    logic c = 1'b0;
    logic r = 1'b1;
    word_lsb_serializer_if #(.WIDTH(WIDTH)) bus ();

    word_lsb_serializer #(.WIDTH(WIDTH)) dut (
        .c   (c),
        .r   (r),
        .bus (bus)
    );

    always #5 c = ~c;

    int         tests    = 0;
    int         fails    = 0;
    int         accepts  = 0;
    int         nbits    = 0;
    logic       rdy_tog  = 1'b0;
    logic [1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
`ifdef SERIALIZER_PARITY_EN
            exp_q.push_back({w[i], 1'b0});
`else
            exp_q.push_back({w[i], (i == WIDTH - 1) ? 1'b1 : 1'b0});
`endif
        end
`ifdef SERIALIZER_PARITY_EN
        exp_q.push_back({^w, 1'b1});
`endif
    endtask

    // Downstream ready: constant 1, or alternating when rdy_tog is set.
    always @(posedge c) begin
        #1;
        bus.ser_ready = rdy_tog ? ~bus.ser_ready : 1'b1;
    end

    logic prev_acc   = 1'b0;
    logic prev_last  = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_data  = 1'b0;

    // Monitor: sample on the falling edge, pop/compare transfers, push on acceptance.
    always @(negedge c) begin
        logic [1:0] e;
        if (r) begin
            prev_acc   = 1'b0;
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_acc) chk("first_bit_latency", bus.ser_valid, 1'b1);
            if (prev_last) begin
                chk("gap_in_ready", bus.in_ready, 1'b1);
                chk("gap_ser_valid", bus.ser_valid, 1'b0);
                chk("gap_busy", bus.busy, 1'b0);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.ser_valid, 1'b1);
                chk("stall_data", bus.ser_data, prev_data);
            end
            if (bus.ser_valid) chk("in_ready_low_in_frame", bus.in_ready, 1'b0);
            else chk("ser_data_zero_idle", bus.ser_data, 1'b0);
            if (bus.ser_valid && bus.ser_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ser_data", bus.ser_data, e[1]);
                    chk("ser_last", bus.ser_last, e[0]);
                end
                nbits++;
            end
            prev_acc = bus.in_valid && bus.in_ready;
            if (prev_acc) begin
                push_word(bus.in_data);
                accepts++;
            end
            prev_last  = bus.ser_valid && bus.ser_ready && bus.ser_last;
            prev_stall = bus.ser_valid && !bus.ser_ready;
            prev_data  = bus.ser_data;
        end
    end

    task automatic send(input logic [WIDTH-1:0] w, input bit keep);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge c);
        while (!bus.in_ready && n < 200) begin
            @(negedge c);
            n++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge c);
        #1;
        if (!keep) begin
            bus.in_valid = 1'b0;
            bus.in_data  = ~w ^ 32'h5A5A_3C3C;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
            @(negedge c);
            n++;
        end
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_busy", bus.busy, 1'b0);
        @(posedge c);
        #1;
    endtask

    initial begin
        int a0;
        int n;
        int n0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        r = 1'b1;
        repeat (2) @(posedge c);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_ser_valid", bus.ser_valid, 1'b0);
        chk("rst_ser_data", bus.ser_data, 1'b0);
        chk("rst_ser_last", bus.ser_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        #2 r = 1'b0;
        @(posedge c);
        #1;

        // Alternating pattern at full rate
        send(32'hAAAA_AAAA, 1'b0);
        wait_idle();

        // Single one with downstream stalling every other cycle
        rdy_tog = 1'b1;
        send(32'h0000_0001, 1'b0);
        wait_idle();
        rdy_tog = 1'b0;
        @(posedge c);
        #1;

        // in_valid held high with changing data: exactly two words accepted in 40 cycles
        a0 = accepts;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.in_data = 32'hC3A5_0000 ^ (32'h0101_0101 * k);
            @(posedge c);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("held_valid_accepts", accepts - a0, 32'd2);
        wait_idle();

`ifdef SERIALIZER_PARITY_EN
        // Parity: 7 has odd weight, 3 even
        send(32'h0000_0007, 1'b0);
        send(32'h0000_0003, 1'b0);
        wait_idle();
`endif

        // Back-to-back all-ones then all-zeros
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h0000_0000, 1'b0);
        wait_idle();

        // Reset mid-frame after 10 bits, then a clean frame
        n0 = nbits;
        n = 0;
        send(32'h1234_5678, 1'b0);
        while (nbits < n0 + 10 && n < 200) begin
            @(negedge c);
            n++;
        end
        if (nbits < n0 + 10) chk("reset_wait_timeout", 32'd1, 32'd0);
        #2 r = 1'b1;
        #1;
        chk("abort_ser_valid", bus.ser_valid, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_ser_last", bus.ser_last, 1'b0);
        exp_q.delete();
        @(posedge c);
        #2 r = 1'b0;
        @(posedge c);
        #1;
        send(32'hA5A5_F00F, 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
